oled_spi_engine: RTL and testbench



---
 rtl/oled_pkg.sv | 28 ++
 rtl/oled_cmd_fifo.sv | 61 ++++++
 rtl/oled_spi_engine.sv | 217 +++++++++++++++++++++
 tb/tb_oled_spi_engine.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306-class OLED serial engine.
// Holds the sequencer state encoding, the default FIFO entry layout and the supply levels.
package oled_pkg;

  localparam int OLED_DATA_W = 8;

  // Panel supply enables are active-low
  localparam logic PWR_ON  = 1'b0;
  localparam logic PWR_OFF = 1'b1;

  typedef enum logic [3:0] {
    OFF,
    VDD_WAIT,
    RES_LOW,
    RES_HI,
    VBAT_WAIT,
    READY,
    LOAD,
    SHIFT,
    DOWN_WAIT
  } oled_state_t;

  typedef struct packed {
    logic                   dc;
    logic [OLED_DATA_W-1:0] data;
  } oled_entry_t;

endpackage

// File: rtl/oled_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO holding {dc, data} entries for the serial engine.
// Push is ignored when full, pop is ignored when empty; flush empties it in one cycle.
module oled_cmd_fifo
  import oled_pkg::*;
#(
  parameter int WIDTH = OLED_DATA_W + 1,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wr_entry,
  output logic [WIDTH-1:0]           rd_entry,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rd_entry = mem[rd_ptr];

  // Depth is a power of two, so the pointers wrap on their own
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/oled_spi_engine.sv
// Buffered SPI engine for SSD1306-class panels: owns the VDD/RES/VBAT power sequence
// and streams {DC, data} entries from the command FIFO over a write-only serial link.
module oled_spi_engine
  import oled_pkg::*;
#(
  parameter int DATA_W     = OLED_DATA_W,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 4,
  parameter int VDD_DLY    = 100000,
  parameter int RES_CYCLES = 300,
  parameter int VBAT_DLY   = 10000000
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic                            pwr_en,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic                            wr_dc,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            busy,
  output logic                            pwr_good,
  output logic                            SDIN,
  output logic                            SCLK,
  output logic                            DC,
  output logic                            RES,
  output logic                            VBAT,
  output logic                            VDD
);

  localparam int MAX_A   = (VDD_DLY > RES_CYCLES) ? VDD_DLY : RES_CYCLES;
  localparam int MAX_DLY = (MAX_A > VBAT_DLY) ? MAX_A : VBAT_DLY;
  localparam int DLY_W   = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);

  oled_state_t       state;
  oled_state_t       state_next;
  logic [DLY_W-1:0]  dly_cnt;
  logic [DLY_W-1:0]  dly_reload;
  logic              dly_done;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic              div_end;
  logic              last_bit;
  logic              word_end;
  logic              sclk_q;
  logic              sdin_q;
  logic              dc_q;

  logic [DATA_W:0]   fifo_rd;
  logic [LVL_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              fifo_flush;

  oled_cmd_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (s00_axi_aclk),
    .rst      (s00_axi_areset),
    .push     (wr_valid),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .wr_entry ({wr_dc, wr_data}),
    .rd_entry (fifo_rd),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign wr_ready   = !fifo_full;
  assign fifo_level = fifo_count;
  assign SCLK       = sclk_q;
  assign SDIN       = sdin_q;
  assign DC         = dc_q;

  assign dly_done   = (dly_cnt == '0);
  assign div_end    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_bit   = (bit_cnt == BIT_W'(DATA_W - 1));
  assign word_end   = (state == SHIFT) && div_end && sclk_q && last_bit;
  assign shreg_next = shreg << 1;

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) state <= OFF;
    else                state <= state_next;
  end

  // A finished word with more entries queued goes straight back to LOAD, so
  // back-to-back words run at one LOAD cycle plus the shift time.
  always_comb begin
    state_next = state;
    VDD        = PWR_ON;
    VBAT       = PWR_OFF;
    RES        = 1'b1;
    pwr_good   = 1'b0;
    busy       = 1'b1;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    case (state)
      OFF: begin
        VDD  = PWR_OFF;
        RES  = 1'b0;
        busy = 1'b0;
        if (pwr_en) state_next = VDD_WAIT;
      end
      VDD_WAIT: begin
        RES = 1'b0;
        if (!pwr_en)       state_next = DOWN_WAIT;
        else if (dly_done) state_next = RES_LOW;
      end
      RES_LOW: begin
        RES = 1'b0;
        if (!pwr_en)       state_next = DOWN_WAIT;
        else if (dly_done) state_next = RES_HI;
      end
      RES_HI: begin
        if (!pwr_en)       state_next = DOWN_WAIT;
        else if (dly_done) state_next = VBAT_WAIT;
      end
      VBAT_WAIT: begin
        VBAT = PWR_ON;
        if (!pwr_en)       state_next = DOWN_WAIT;
        else if (dly_done) state_next = READY;
      end
      READY: begin
        VBAT     = PWR_ON;
        pwr_good = 1'b1;
        busy     = !fifo_empty;
        if (!pwr_en)          state_next = DOWN_WAIT;
        else if (!fifo_empty) state_next = LOAD;
      end
      LOAD: begin
        VBAT       = PWR_ON;
        pwr_good   = 1'b1;
        fifo_pop   = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        VBAT     = PWR_ON;
        pwr_good = 1'b1;
        if (word_end) begin
          if (!pwr_en)          state_next = DOWN_WAIT;
          else if (!fifo_empty) state_next = LOAD;
          else                  state_next = READY;
        end
      end
      DOWN_WAIT: begin
        fifo_flush = 1'b1;
        if (dly_done) state_next = OFF;
      end
      default: state_next = OFF;
    endcase
  end

  always_comb begin
    dly_reload = '0;
    case (state_next)
      VDD_WAIT:           dly_reload = DLY_W'(VDD_DLY - 1);
      RES_LOW, RES_HI:    dly_reload = DLY_W'(RES_CYCLES - 1);
      VBAT_WAIT, DOWN_WAIT: dly_reload = DLY_W'(VBAT_DLY - 1);
      default:            dly_reload = '0;
    endcase
  end

  // One shared down-counter, reloaded on every state change
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset)           dly_cnt <= '0;
    else if (state_next != state) dly_cnt <= dly_reload;
    else if (!dly_done)           dly_cnt <= dly_cnt - DLY_W'(1);
  end

  // SDIN only moves together with a falling SCLK so the panel sees a stable bit on each rise
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      sclk_q  <= 1'b1;
      sdin_q  <= 1'b0;
      dc_q    <= 1'b0;
      shreg   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        LOAD: begin
          dc_q    <= fifo_rd[DATA_W];
          sdin_q  <= fifo_rd[DATA_W-1];
          shreg   <= fifo_rd[DATA_W-1:0];
          sclk_q  <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          if (div_end) begin
            div_cnt <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else if (!last_bit) begin
              sclk_q  <= 1'b0;
              bit_cnt <= bit_cnt + BIT_W'(1);
              shreg   <= shreg_next;
              sdin_q  <= shreg_next[DATA_W-1];
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: sclk_q <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_spi_engine.sv
// Scoreboard bench for oled_spi_engine: pushes random entries, decodes the serial
// link independently and checks power sequencing against delay arithmetic.
module tb_oled_spi_engine;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int CLK_DIV    = 2;
  localparam int VDD_DLY    = 10;
  localparam int RES_CYCLES = 5;
  localparam int VBAT_DLY   = 20;
  localparam int WORD_CYC   = 1 + 2 * CLK_DIV * DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pwr_en = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_dc = 1'b0;
  logic [4:0]        fifo_level;
  logic              busy, pwr_good, SDIN, SCLK, DC, RES, VBAT, VDD;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  logic [DATA_W:0] exp_q [$];
  int              done_q [$];
  int              words_done = 0;

  int              mon_bits = 0;
  int              run_len = 0;
  logic            prev_sclk = 1'b1;
  logic            prev_sdin = 1'b0;
  logic            phase_err = 1'b0;
  logic [DATA_W-1:0] mon_sh = '0;

  oled_spi_engine #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CLK_DIV    (CLK_DIV),
    .VDD_DLY    (VDD_DLY),
    .RES_CYCLES (RES_CYCLES),
    .VBAT_DLY   (VBAT_DLY)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (rst),
    .pwr_en         (pwr_en),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_data        (wr_data),
    .wr_dc          (wr_dc),
    .fifo_level     (fifo_level),
    .busy           (busy),
    .pwr_good       (pwr_good),
    .SDIN           (SDIN),
    .SCLK           (SCLK),
    .DC             (DC),
    .RES            (RES),
    .VBAT           (VBAT),
    .VDD            (VDD)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic checkRange(input string name, input longint actual, input longint lo, input longint hi);
    checks++;
    if (actual >= lo && actual <= hi) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
  endtask

  // Offers one entry for one cycle; the model records it only if the DUT took it
  task automatic applyStimulus(input logic dc, input logic [DATA_W-1:0] data, output logic accepted);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_dc    = dc;
    wr_data  = data;
    accepted = wr_ready;
    @(posedge clk);
    if (accepted) exp_q.push_back({dc, data});
    #1 wr_valid = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    for (int i = 0; i < limit && busy; i++) @(negedge clk);
  endtask

  // Serial decoder: bits are taken on SCLK rises, phase lengths and SDIN stability tracked
  always @(negedge clk) begin
    if (rst) begin
      mon_bits  = 0;
      run_len   = 0;
      prev_sclk = 1'b1;
      prev_sdin = SDIN;
      phase_err = 1'b0;
    end else begin
      if (SCLK !== prev_sclk) begin
        if (SCLK === 1'b1) begin
          if (run_len != CLK_DIV) phase_err = 1'b1;
          if (SDIN !== prev_sdin) phase_err = 1'b1;
          mon_sh = {mon_sh[DATA_W-2:0], SDIN};
          mon_bits++;
          if (mon_bits == DATA_W) begin
            checkOutput("word_expected_present", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) checkOutput("word_content", {DC, mon_sh}, exp_q.pop_front());
            checkOutput("sclk_sdin_timing", phase_err, 0);
            phase_err = 1'b0;
            mon_bits  = 0;
            done_q.push_back(cyc);
            words_done++;
          end
        end else begin
          if (mon_bits != 0 && run_len != CLK_DIV) phase_err = 1'b1;
        end
        run_len = 1;
      end else begin
        run_len++;
        if (SCLK === 1'b1 && mon_bits != 0 && SDIN !== prev_sdin) phase_err = 1'b1;
      end
      prev_sclk = SCLK;
      prev_sdin = SDIN;
    end
  end

  initial begin
    logic acc;
    int   t_vdd, t_res, t_vbat, t_good, n, target, t0, t1;

    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_sclk", SCLK, 1);
    checkOutput("rst_sdin", SDIN, 0);
    checkOutput("rst_dc", DC, 0);
    checkOutput("rst_res", RES, 0);
    checkOutput("rst_vdd", VDD, 1);
    checkOutput("rst_vbat", VBAT, 1);
    checkOutput("rst_pwr_good", pwr_good, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_fifo_level", fifo_level, 0);
    checkOutput("rst_wr_ready", wr_ready, 1);

    $display("[TB] fill FIFO while powered off");
    for (int k = 0; k < FIFO_DEPTH; k++) applyStimulus(1'($urandom), DATA_W'($urandom), acc);
    @(negedge clk);
    checkOutput("full_level", fifo_level, FIFO_DEPTH);
    checkOutput("full_wr_ready", wr_ready, 0);
    applyStimulus(1'b1, 8'h5A, acc);
    checkOutput("overflow_refused", acc, 0);
    @(negedge clk);
    checkOutput("overflow_level", fifo_level, FIFO_DEPTH);
    checkOutput("off_no_words", words_done, 0);

    $display("[TB] power-up sequence");
    done_q.delete();
    t_vdd = -1; t_res = -1; t_vbat = -1; t_good = -1;
    pwr_en = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (t_vdd  < 0 && VDD == 1'b0)  t_vdd  = i;
      if (t_res  < 0 && RES == 1'b1)  t_res  = i;
      if (t_vbat < 0 && VBAT == 1'b0) t_vbat = i;
      if (t_good < 0 && pwr_good)     t_good = i;
    end
    checkOutput("vdd_on_cycle", t_vdd, 1);
    checkOutput("res_release_cycle", t_res, 1 + VDD_DLY + RES_CYCLES);
    checkOutput("vbat_on_cycle", t_vbat, 1 + VDD_DLY + 2 * RES_CYCLES);
    checkRange("pwr_good_cycle", t_good, VDD_DLY + 2 * RES_CYCLES + VBAT_DLY,
               2 + VDD_DLY + 2 * RES_CYCLES + VBAT_DLY);
    for (int i = 0; i < FIFO_DEPTH * (WORD_CYC + 4) && words_done < FIFO_DEPTH; i++) @(negedge clk);
    checkOutput("burst_words", words_done, FIFO_DEPTH);
    for (int k = 1; k < done_q.size(); k++) checkOutput("burst_word_gap", done_q[k] - done_q[k-1], WORD_CYC);

    $display("[TB] single command word 0xAF");
    waitIdle(100);
    applyStimulus(1'b0, 8'hAF, acc);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    checkOutput("busy_length", n, 1 + WORD_CYC);
    checkOutput("dc_after_word", DC, 0);
    checkOutput("sclk_idle_high", SCLK, 1);

    $display("[TB] random traffic");
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'($urandom), DATA_W'($urandom), acc);
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
    checkOutput("random_drained", exp_q.size(), 0);

    $display("[TB] power-down mid-word");
    waitIdle(100);
    for (int k = 0; k < 6; k++) applyStimulus(1'($urandom), DATA_W'($urandom), acc);
    for (int i = 0; i < 200 && mon_bits != 3; i++) @(negedge clk);
    checkOutput("reach_bit3", mon_bits, 3);
    checkOutput("queued_before_down", fifo_level, 5);
    pwr_en = 1'b0;
    target = words_done + 1;
    for (int i = 0; i < 100 && words_done < target; i++) @(negedge clk);
    checkOutput("word_completes", words_done, target);
    exp_q.delete();
    t0 = -1; t1 = -1;
    for (int i = 0; i < 200; i++) begin
      if (t0 < 0 && VBAT == 1'b1) t0 = i;
      if (t1 < 0 && VDD == 1'b1)  t1 = i;
      if (t0 == i + 0 && t0 >= 0 && i == t0) ;
      if (t0 >= 0 && i == t0 + 2) begin
        checkOutput("down_fifo_flushed", fifo_level, 0);
        checkOutput("down_pwr_good", pwr_good, 0);
      end
      if (t1 >= 0) break;
      @(negedge clk);
    end
    checkOutput("vbat_to_vdd_off", t1 - t0, VBAT_DLY);
    checkOutput("down_res_low", RES, 0);

    $display("[TB] reset during shift");
    pwr_en = 1'b1;
    for (int i = 0; i < 200 && !pwr_good; i++) @(negedge clk);
    checkOutput("repower_good", pwr_good, 1);
    for (int k = 0; k < 3; k++) applyStimulus(1'($urandom), DATA_W'($urandom), acc);
    for (int i = 0; i < 200 && mon_bits < 2; i++) @(negedge clk);
    checkOutput("reset_pre_level", fifo_level, 2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("areset_sclk", SCLK, 1);
    checkOutput("areset_vdd", VDD, 1);
    checkOutput("areset_vbat", VBAT, 1);
    checkOutput("areset_res", RES, 0);
    checkOutput("areset_level", fifo_level, 0);
    checkOutput("areset_busy", busy, 0);
    exp_q.delete();
    pwr_en = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    target = words_done;
    repeat (60) @(negedge clk);
    checkOutput("no_words_after_reset", words_done, target);
    checkOutput("post_reset_vdd", VDD, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
